pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller_pkg.sv | 21 ++
 rtl/pipeline_controller_hazard_detector.sv | 25 ++
 rtl/pipeline_controller.sv | 120 ++++++++++++
 tb/tb_pipeline_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_controller_pkg : shared widths and controller state encodings
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_controller_pkg;

  localparam int INSTRUCTION_LEN     = 32;
  localparam int EXECUTE_COMMAND_LEN = 4;
  localparam int REG_ADDR_LEN        = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/pipeline_controller_hazard_detector.sv
// ---------------------------------------------------------------------------
// hazard_detector : load-use hazard between the ID and EX instructions
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_detector
  import pipeline_controller_pkg::*;
(
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_two_src,
  input  logic [REG_ADDR_LEN-1:0] ex_dest,
  input  logic                    ex_mem_read,
  output logic                    hazard
);

  // Register 0 is deliberately treated like any other register.
  assign hazard = id_valid & ex_mem_read &
                  ((id_src1 == ex_dest) | (id_two_src & (id_src2 == ex_dest)));

endmodule

`default_nettype wire

// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller : stall/flush control with memory-wait FSM and timeout
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_two_src,
  input  logic [REG_ADDR_LEN-1:0] ex_dest,
  input  logic                    ex_mem_read,
  input  logic                    branch_taken,
  input  logic                    mem_req,
  input  logic                    mem_ready,
  output logic                    pc_enable,
  output logic                    if_id_enable,
  output logic                    id_ex_enable,
  output logic                    ex_mem_enable,
  output logic                    mem_wb_enable,
  output logic                    if_id_flush,
  output logic                    id_ex_flush,
  output logic                    mem_timeout,
  output logic [15:0]             stall_cycles,
  output logic [1:0]              state
);

  localparam int CNT_W = ($clog2(MEM_TIMEOUT) > 8) ? $clog2(MEM_TIMEOUT) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e      state_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]      stall_q;
  logic             hazard;
  logic             freeze;

  hazard_detector u_hazard_detector (
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .ex_dest     (ex_dest),
    .ex_mem_read (ex_mem_read),
    .hazard      (hazard)
  );

  assign freeze = ((state_q == ST_RUN) & mem_req & ~mem_ready) |
                  ((state_q == ST_MEM_WAIT) & ~mem_ready) |
                  (state_q == ST_TIMEOUT);

  // Priority: reset bubble, then memory freeze, then branch flush, then load-use stall.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    if (rst) begin
      {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable} = 5'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable} = 5'b0;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hazard) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      wait_cnt <= '0;
      stall_q  <= 16'd0;
    end else begin
      if (!pc_enable && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state_q  <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state_q <= ST_RUN;
          end else if (wait_cnt == CNT_LAST) begin
            state_q <= ST_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_TIMEOUT: state_q <= ST_TIMEOUT;
        default:    state_q <= ST_RUN;
      endcase
    end
  end

  assign mem_timeout  = (state_q == ST_TIMEOUT);
  assign stall_cycles = stall_q;
  assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_controller : vector table plus scoreboard for pipeline_controller
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_controller;

  typedef struct {
    string       name;
    logic        rst;
    logic        id_valid;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic [3:0]  dest;
    logic        mem_read;
    logic        branch;
    logic        mreq;
    logic        mrdy;
    logic [6:0]  exp_out;   // pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush
    logic [1:0]  exp_state;
    logic [15:0] exp_stall;
    logic        exp_to;
  } vec_t;

  localparam logic [6:0] RUN_ALL = 7'b1111100;
  localparam logic [6:0] HAZ     = 7'b0011101;
  localparam logic [6:0] BRANCH  = 7'b1111111;
  localparam logic [6:0] FROZEN  = 7'b0000000;
  localparam logic [6:0] RESET   = 7'b0000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_two_src = 1'b0, ex_mem_read = 1'b0;
  logic branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic [3:0] id_src1 = 4'd0, id_src2 = 4'd0, ex_dest = 4'd0;
  logic pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic if_id_flush, id_ex_flush, mem_timeout;
  logic [15:0] stall_cycles;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_controller #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
    .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .state(state)
  );

  function automatic vec_t v(string n, logic r, logic iv, logic [3:0] s1, logic [3:0] s2,
                             logic two, logic [3:0] d, logic mr, logic br, logic rq,
                             logic rd, logic [6:0] o, logic [1:0] st, logic [15:0] sc,
                             logic to);
    vec_t x;
    x.name = n; x.rst = r; x.id_valid = iv; x.src1 = s1; x.src2 = s2; x.two_src = two;
    x.dest = d; x.mem_read = mr; x.branch = br; x.mreq = rq; x.mrdy = rd;
    x.exp_out = o; x.exp_state = st; x.exp_stall = sc; x.exp_to = to;
    return x;
  endfunction

  function automatic vec_t idle(string n, logic [1:0] st, logic [15:0] sc);
    return v(n, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUN_ALL, st, sc, 1'b0);
  endfunction

  function automatic vec_t memw(string n, logic rd, logic br, logic [6:0] o, logic [1:0] st,
                                logic [15:0] sc, logic to);
    return v(n, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 4'd3, 1'b1, br, 1'b1, rd, o, st, sc, to);
  endfunction

  task automatic drive(input vec_t x);
    rst = x.rst; id_valid = x.id_valid; id_src1 = x.src1; id_src2 = x.src2;
    id_two_src = x.two_src; ex_dest = x.dest; ex_mem_read = x.mem_read;
    branch_taken = x.branch; mem_req = x.mreq; mem_ready = x.mrdy;
  endtask

  task automatic check(input string n, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic step(input vec_t x);
    vec_t e;
    @(posedge clk);
    #1;
    drive(x);
    exp_q.push_back(x);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", x.name);
    end else begin
      e = exp_q.pop_front();
      check({e.name, ".out"}, 16'({pc_enable, if_id_enable, id_ex_enable, ex_mem_enable,
            mem_wb_enable, if_id_flush, id_ex_flush}), 16'(e.exp_out));
      check({e.name, ".state"}, 16'(state), 16'(e.exp_state));
      check({e.name, ".stall"}, stall_cycles, e.exp_stall);
      check({e.name, ".timeout"}, 16'(mem_timeout), 16'(e.exp_to));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step(v("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RESET, 2'd0, 16'd0, 0));

    tbl.push_back(idle("idle0", 2'd0, 16'd0));
    tbl.push_back(v("haz_src1", 0, 1, 4'd3, 4'd0, 0, 4'd3, 1, 0, 0, 0, HAZ, 2'd0, 16'd0, 0));
    tbl.push_back(idle("idle1", 2'd0, 16'd1));
    tbl.push_back(v("haz_branch", 0, 1, 4'd3, 4'd0, 0, 4'd3, 1, 1, 0, 0, BRANCH, 2'd0, 16'd1, 0));
    tbl.push_back(idle("idle2", 2'd0, 16'd1));
    tbl.push_back(v("haz_src2", 0, 1, 4'd5, 4'd7, 1, 4'd7, 1, 0, 0, 0, HAZ, 2'd0, 16'd1, 0));
    tbl.push_back(v("src2_unused", 0, 1, 4'd5, 4'd7, 0, 4'd7, 1, 0, 0, 0, RUN_ALL, 2'd0, 16'd2, 0));
    tbl.push_back(v("id_invalid", 0, 0, 4'd3, 4'd0, 0, 4'd3, 1, 0, 0, 0, RUN_ALL, 2'd0, 16'd2, 0));
    tbl.push_back(v("not_load", 0, 1, 4'd3, 4'd0, 0, 4'd3, 0, 0, 0, 0, RUN_ALL, 2'd0, 16'd2, 0));
    tbl.push_back(v("reg0_haz", 0, 1, 4'd0, 4'd9, 1, 4'd0, 1, 0, 0, 0, HAZ, 2'd0, 16'd2, 0));
    tbl.push_back(v("mem_1cyc", 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1, 1, RUN_ALL, 2'd0, 16'd3, 0));
    tbl.push_back(idle("idle3", 2'd0, 16'd3));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Four frozen cycles, then the access completes; hazard and branch are ignored while frozen.
    step(memw("mw_c0", 0, 0, FROZEN, 2'd0, 16'd3, 0));
    step(memw("mw_c1", 0, 1, FROZEN, 2'd1, 16'd4, 0));
    step(memw("mw_c2", 0, 0, FROZEN, 2'd1, 16'd5, 0));
    step(memw("mw_c3", 0, 0, FROZEN, 2'd1, 16'd6, 0));
    step(v("mw_done", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN_ALL, 2'd1, 16'd7, 0));
    step(idle("mw_back", 2'd0, 16'd7));

    // Reset while waiting on memory.
    step(memw("rw_enter", 0, 0, FROZEN, 2'd0, 16'd7, 0));
    step(v("rw_rst", 1, 1, 4'd3, 0, 0, 4'd3, 1, 1, 1, 0, RESET, 2'd1, 16'd8, 0));
    step(idle("rw_after", 2'd0, 16'd0));

    // Timeout with MEM_TIMEOUT=8: entry cycle plus eight waiting cycles.
    step(memw("to_c0", 0, 0, FROZEN, 2'd0, 16'd0, 0));
    for (int i = 1; i <= 8; i++) step(memw("to_wait", 0, 0, FROZEN, 2'd1, 16'(i), 0));
    step(memw("to_abs", 1, 1, FROZEN, 2'd2, 16'd9, 1));
    step(memw("to_hold", 0, 0, FROZEN, 2'd2, 16'd10, 1));
    step(v("to_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, RESET, 2'd2, 16'd11, 1));
    step(idle("to_clear", 2'd0, 16'd0));

    // mem_ready on the last allowed wait cycle returns to RUN instead of timing out.
    step(memw("edge_c0", 0, 0, FROZEN, 2'd0, 16'd0, 0));
    for (int i = 1; i <= 7; i++) step(memw("edge_wait", 0, 0, FROZEN, 2'd1, 16'(i), 0));
    step(v("edge_rdy", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN_ALL, 2'd1, 16'd8, 0));
    step(idle("edge_run", 2'd0, 16'd8));

    // Saturation of the stall counter.
    @(posedge clk);
    #1;
    drive(v("sat", 0, 1, 4'd3, 4'd0, 0, 4'd3, 1, 0, 0, 0, HAZ, 2'd0, 16'd0, 0));
    repeat (65539) @(posedge clk);
    step(v("sat_hi", 0, 1, 4'd3, 4'd0, 0, 4'd3, 1, 0, 0, 0, HAZ, 2'd0, 16'hFFFF, 0));
    step(v("sat_hold", 0, 1, 4'd3, 4'd0, 0, 4'd3, 1, 0, 0, 0, HAZ, 2'd0, 16'hFFFF, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
